// File: rtl/lite_wr_arbiter_pkg.sv
// Shared types and constants for the two-port AXI-Lite write arbiter.
// Holds the one-hot FSM encoding, port indices, default widths and the grant-pick helper.
package lite_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_MM2S = 1'b0;
    localparam logic PORT_S2MM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_ISSUE    = 3'b010,
        ST_WAIT_END = 3'b100
    } arb_state_e;

    // With both slots full the pointer decides; otherwise the only full slot wins.
    function automatic logic pick_port(input logic full0, input logic full1, input logic prio);
        if (full0 && full1) begin
            return prio;
        end
        return full1 ? PORT_S2MM : PORT_MM2S;
    endfunction

endpackage

// File: rtl/lite_wr_arbiter_if.sv
// AXI-Lite write-master command bus: the arbiter drives it (master), the
// AXI-Lite write engine consumes it and returns the completion pulse (slave).
interface lite_wr_arbiter_if
    import lite_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] lite_awaddr;
    logic [DATA_W-1:0] lite_wdata;
    logic              lite_valid;
    logic              lite_end;

    modport master (
        output lite_awaddr,
        output lite_wdata,
        output lite_valid,
        input  lite_end
    );

    modport slave (
        input  lite_awaddr,
        input  lite_wdata,
        input  lite_valid,
        output lite_end
    );

endinterface

// File: rtl/lite_req_slot.sv
// Single-entry request buffer for one requester: captures addr/data on a
// request pulse when empty (or when being released), otherwise flags a sticky drop.
module lite_req_slot
    import lite_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              full,
    output logic [ADDR_W-1:0] slot_awaddr,
    output logic [DATA_W-1:0] slot_wdata,
    output logic              drop
);

    logic take;

    // A request arriving in the release cycle refills the slot instead of being dropped.
    assign take = valid && (!full || clr);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            drop <= 1'b0;
        end else begin
            if (take) begin
                full <= 1'b1;
            end else if (clr) begin
                full <= 1'b0;
            end
            if (valid && !take) begin
                drop <= 1'b1;
            end
        end
    end

    // NOTE: payload registers are not reset; they are only consumed while full is set.
    always_ff @(posedge clk) begin
        if (take) begin
            slot_awaddr <= awaddr;
            slot_wdata  <= wdata;
        end
    end

endmodule

// File: rtl/lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write master between MM2S and S2MM control.
// Optional completion timeout enabled by defining LITE_ARB_TIMEOUT_EN.
module lite_wr_arbiter
    import lite_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_valid,
    output logic              m0_end,
    output logic              m0_busy,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_valid,
    output logic              m1_end,
    output logic              m1_busy,
    lite_wr_arbiter_if.master lite,
    output logic [1:0]        req_drop,
    output logic              arb_err
);

    arb_state_e        state_q, state_d;
    logic              full0, full1, drop0, drop1;
    logic [ADDR_W-1:0] slot_awaddr0, slot_awaddr1, awaddr_q;
    logic [DATA_W-1:0] slot_wdata0, slot_wdata1, wdata_q;
    logic              grant_q, prio_q, grant_sel;
    logic              start, done, tmo_hit;
    logic [1:0]        end_q;

    assign start     = (state_q == ST_IDLE) && (full0 || full1);
    assign grant_sel = pick_port(full0, full1, prio_q);
    assign done      = (state_q != ST_IDLE) && (lite.lite_end || tmo_hit);

    lite_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .clk(clk), .rst(rst), .valid(m0_valid), .awaddr(m0_awaddr), .wdata(m0_wdata),
        .clr(done && (grant_q == PORT_MM2S)), .full(full0),
        .slot_awaddr(slot_awaddr0), .slot_wdata(slot_wdata0), .drop(drop0)
    );

    lite_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk(clk), .rst(rst), .valid(m1_valid), .awaddr(m1_awaddr), .wdata(m1_wdata),
        .clr(done && (grant_q == PORT_S2MM)), .full(full1),
        .slot_awaddr(slot_awaddr1), .slot_wdata(slot_wdata1), .drop(drop1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d defaults to the current state so every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_ISSUE;
            ST_ISSUE:    state_d = done ? ST_IDLE : ST_WAIT_END;
            ST_WAIT_END: if (done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lite.lite_valid  = (state_q == ST_ISSUE);
        lite.lite_awaddr = awaddr_q;
        lite.lite_wdata  = wdata_q;
        m0_end           = end_q[0];
        m1_end           = end_q[1];
        m0_busy          = full0;
        m1_busy          = full1;
        req_drop         = {drop1, drop0};
    end

    // Bus payload is loaded at grant and held until the arbiter sits idle with nothing to grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= PORT_MM2S;
            prio_q   <= PORT_MM2S;
            awaddr_q <= '0;
            wdata_q  <= '0;
            end_q    <= '0;
        end else begin
            end_q <= '0;
            if (start) begin
                grant_q  <= grant_sel;
                awaddr_q <= (grant_sel == PORT_S2MM) ? slot_awaddr1 : slot_awaddr0;
                wdata_q  <= (grant_sel == PORT_S2MM) ? slot_wdata1 : slot_wdata0;
            end else if (state_q == ST_IDLE) begin
                awaddr_q <= '0;
                wdata_q  <= '0;
            end
            if (done) begin
                end_q[grant_q] <= 1'b1;
                prio_q         <= ~grant_q;
            end
        end
    end

`ifdef LITE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             arb_err_q;

    // Counter is zero in the ISSUE cycle, so the abort lands TIMEOUT_CYC cycles after ISSUE.
    assign tmo_hit = (state_q != ST_IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign arb_err = arb_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            arb_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) || done) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                arb_err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_lite_wr_arbiter.sv
// Self-checking bench for lite_wr_arbiter: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed cycle/value expectations.
module tb_lite_wr_arbiter;
    import lite_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m0_awaddr, m1_awaddr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_valid, m1_valid;
    logic          m0_end, m1_end, m0_busy, m1_busy;
    logic [1:0]    req_drop;
    logic          arb_err;

    lite_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) lite_bus ();

    lite_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_awaddr(m0_awaddr), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
        .m0_end(m0_end), .m0_busy(m0_busy),
        .m1_awaddr(m1_awaddr), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
        .m1_end(m1_end), .m1_busy(m1_busy),
        .lite(lite_bus),
        .req_drop(req_drop), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // AXI-Lite engine stand-in: completes resp_lat cycles after lite_valid, plus manual pulses.
    bit resp_en = 1'b0;
    int resp_lat = 4;
    bit man_end = 1'b0;
    initial begin
        int cd;
        cd = 0;
        lite_bus.lite_end = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            lite_bus.lite_end = man_end;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) lite_bus.lite_end = 1'b1;
                end
                if (lite_bus.lite_valid && resp_en) cd = resp_lat;
            end
        end
    end

    // Reference model: pending slots, one write in flight, round-robin preference.
    bit            m_pend[2];
    logic [AW-1:0] m_paddr[2];
    logic [DW-1:0] m_pdata[2];
    bit            m_inflight;
    int            m_owner, m_age, m_prio;
    bit [1:0]      m_drop;
    bit            m_err;
    bit            e_valid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit [1:0]      e_end;
    bit            armed = 1'b0;

    int            iss_cyc[$];
    logic [AW-1:0] iss_addr[$];
    logic [DW-1:0] iss_data[$];
    int            end0_cyc[$];
    int            end1_cyc[$];

    task automatic model_step();
        bit            complete, tmo, grant;
        int            g;
        bit            v[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] d[2];
        v[0] = m0_valid; a[0] = m0_awaddr; d[0] = m0_wdata;
        v[1] = m1_valid; a[1] = m1_awaddr; d[1] = m1_wdata;
        e_valid = 1'b0;
        e_end   = '0;
        if (rst) begin
            m_pend[0] = 1'b0; m_pend[1] = 1'b0;
            m_inflight = 1'b0; m_owner = 0; m_age = 0; m_prio = 0;
            m_drop = '0; m_err = 1'b0;
            return;
        end
        tmo = 1'b0;
`ifdef LITE_ARB_TIMEOUT_EN
        tmo = m_inflight && (m_age == TO - 1);
`endif
        complete = m_inflight && (lite_bus.lite_end || tmo);
        grant    = !m_inflight && (m_pend[0] || m_pend[1]);
        if (complete) begin
            e_end[m_owner]  = 1'b1;
            m_pend[m_owner] = 1'b0;
            m_prio          = 1 - m_owner;
            m_inflight      = 1'b0;
            if (tmo) m_err = 1'b1;
        end else if (m_inflight) begin
            m_age++;
        end
        if (grant) begin
            g = (m_pend[0] && m_pend[1]) ? m_prio : (m_pend[1] ? 1 : 0);
            m_owner    = g;
            m_inflight = 1'b1;
            m_age      = 0;
            e_valid    = 1'b1;
            e_addr     = m_paddr[g];
            e_data     = m_pdata[g];
        end
        for (int n = 0; n < 2; n++) begin
            if (v[n]) begin
                if (!m_pend[n]) begin
                    m_pend[n]  = 1'b1;
                    m_paddr[n] = a[n];
                    m_pdata[n] = d[n];
                end else begin
                    m_drop[n] = 1'b1;
                end
            end
        end
    endtask

    // Compare process: mid-cycle, check DUT against the model, log bus events, then advance the model.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("lite_valid", 64'(lite_bus.lite_valid), 64'(e_valid));
            if (e_valid) begin
                check("lite_awaddr", 64'(lite_bus.lite_awaddr), 64'(e_addr));
                check("lite_wdata", 64'(lite_bus.lite_wdata), 64'(e_data));
            end
            check("m0_end", 64'(m0_end), 64'(e_end[0]));
            check("m1_end", 64'(m1_end), 64'(e_end[1]));
            check("m0_busy", 64'(m0_busy), 64'(m_pend[0]));
            check("m1_busy", 64'(m1_busy), 64'(m_pend[1]));
            check("req_drop", 64'(req_drop), 64'(m_drop));
            check("arb_err", 64'(arb_err), 64'(m_err));
        end
        if (lite_bus.lite_valid === 1'b1) begin
            iss_cyc.push_back(cyc);
            iss_addr.push_back(lite_bus.lite_awaddr);
            iss_data.push_back(lite_bus.lite_wdata);
        end
        if (m0_end === 1'b1) end0_cyc.push_back(cyc);
        if (m1_end === 1'b1) end1_cyc.push_back(cyc);
        model_step();
        if (rst) armed = 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    int b, b2, e0b, e1b, c, c2, r0, r1;

    initial begin
        m0_valid = 1'b0; m0_awaddr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_awaddr = '0; m1_wdata = '0;
        #1;
        do_reset(3);

        check("rst lite_valid", 64'(lite_bus.lite_valid), 64'd0);
        check("rst lite_awaddr", 64'(lite_bus.lite_awaddr), 64'd0);
        check("rst busy", 64'({m1_busy, m0_busy}), 64'd0);
        check("rst req_drop", 64'(req_drop), 64'd0);
        check("rst arb_err", 64'(arb_err), 64'd0);

        // Single m0 write, completion 4 cycles after lite_valid.
        resp_en = 1'b1; resp_lat = 4;
        b = iss_cyc.size(); e0b = end0_cyc.size();
        c = cyc;
        m0_valid = 1'b1; m0_awaddr = 10'h000; m0_wdata = 32'h0101_1005;
        tick();
        m0_valid = 1'b0;
        tick(12);
        check("t1 issue count", 64'(iss_cyc.size() - b), 64'd1);
        if (iss_cyc.size() > b) begin
            check("t1 issue cycle", 64'(iss_cyc[b] - c), 64'd2);
            check("t1 issue addr", 64'(iss_addr[b]), 64'h000);
            check("t1 issue data", 64'(iss_data[b]), 64'h0101_1005);
        end
        check("t1 end count", 64'(end0_cyc.size() - e0b), 64'd1);
        if (end0_cyc.size() > e0b) check("t1 end cycle", 64'(end0_cyc[e0b] - c), 64'd7);
        check("t1 m0_busy after", 64'(m0_busy), 64'd0);

        // Simultaneous requests after reset: port 0 first.
        do_reset(2);
        b = iss_cyc.size(); e0b = end0_cyc.size(); e1b = end1_cyc.size();
        c = cyc;
        m0_valid = 1'b1; m0_awaddr = 10'h018; m0_wdata = 32'h1000_0000;
        m1_valid = 1'b1; m1_awaddr = 10'h048; m1_wdata = 32'h2000_0000;
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick(20);
        check("t2 issue count", 64'(iss_cyc.size() - b), 64'd2);
        if (iss_cyc.size() > b + 1) begin
            check("t2 first addr", 64'(iss_addr[b]), 64'h018);
            check("t2 second addr", 64'(iss_addr[b+1]), 64'h048);
            check("t2 second data", 64'(iss_data[b+1]), 64'h2000_0000);
            check("t2 second issue cycle", 64'(iss_cyc[b+1] - c), 64'd8);
        end
        if (end0_cyc.size() > e0b) check("t2 m0_end cycle", 64'(end0_cyc[e0b] - c), 64'd7);
        else check("t2 m0_end seen", 64'd0, 64'd1);
        if (end1_cyc.size() > e1b) check("t2 m1_end cycle", 64'(end1_cyc[e1b] - c), 64'd13);
        else check("t2 m1_end seen", 64'd0, 64'd1);

        // Both slots refilled on their end pulse: grant order 0,1,0,1.
        do_reset(2);
        b = iss_cyc.size();
        m0_valid = 1'b1; m0_awaddr = 10'h010; m0_wdata = 32'h0000_00A0;
        m1_valid = 1'b1; m1_awaddr = 10'h030; m1_wdata = 32'h0000_00B0;
        tick();
        r0 = 0; r1 = 0;
        for (int k = 0; k < 40; k++) begin
            m0_valid = 1'b0; m1_valid = 1'b0;
            if (m0_end && r0 == 0) begin
                m0_valid = 1'b1; m0_awaddr = 10'h020; m0_wdata = 32'h0000_00A1; r0++;
            end
            if (m1_end && r1 == 0) begin
                m1_valid = 1'b1; m1_awaddr = 10'h040; m1_wdata = 32'h0000_00B1; r1++;
            end
            tick();
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        check("t3 issue count", 64'(iss_cyc.size() - b), 64'd4);
        if (iss_cyc.size() > b + 3) begin
            check("t3 grant 1", 64'(iss_addr[b]),   64'h010);
            check("t3 grant 2", 64'(iss_addr[b+1]), 64'h030);
            check("t3 grant 3", 64'(iss_addr[b+2]), 64'h020);
            check("t3 grant 4", 64'(iss_addr[b+3]), 64'h040);
        end
        check("t3 req_drop", 64'(req_drop), 64'd0);

        // Second m1 request while busy is dropped.
        do_reset(2);
        b = iss_cyc.size(); e1b = end1_cyc.size();
        c = cyc;
        m1_valid = 1'b1; m1_awaddr = 10'h048; m1_wdata = 32'h2000_0000;
        tick();
        m1_valid = 1'b0;
        tick();
        check("t4 m1_busy", 64'(m1_busy), 64'd1);
        m1_valid = 1'b1; m1_awaddr = 10'h04C; m1_wdata = 32'hDEAD_BEEF;
        tick();
        m1_valid = 1'b0;
        tick(12);
        check("t4 req_drop", 64'(req_drop), 64'b10);
        check("t4 issue count", 64'(iss_cyc.size() - b), 64'd1);
        if (iss_cyc.size() > b) check("t4 issue addr", 64'(iss_addr[b]), 64'h048);
        if (end1_cyc.size() > e1b) check("t4 m1_end cycle", 64'(end1_cyc[e1b] - c), 64'd7);
        else check("t4 m1_end seen", 64'd0, 64'd1);

        // Reset while waiting for completion, then a stray lite_end.
        resp_en = 1'b0;
        do_reset(2);
        b = iss_cyc.size(); e0b = end0_cyc.size(); e1b = end1_cyc.size();
        c = cyc;
        m0_valid = 1'b1; m0_awaddr = 10'h008; m0_wdata = 32'h0000_0011;
        tick();
        m0_valid = 1'b0;
        tick(3);
        check("t5 wait busy", 64'(m0_busy), 64'd1);
        check("t5 wait awaddr", 64'(lite_bus.lite_awaddr), 64'h008);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 post-rst lite_valid", 64'(lite_bus.lite_valid), 64'd0);
        check("t5 post-rst awaddr", 64'(lite_bus.lite_awaddr), 64'd0);
        check("t5 post-rst busy", 64'(m0_busy), 64'd0);
        man_end = 1'b1;
        tick();
        man_end = 1'b0;
        tick(3);
        check("t5 no end pulses", 64'((end0_cyc.size() - e0b) + (end1_cyc.size() - e1b)), 64'd0);
        resp_en = 1'b1;
        b2 = iss_cyc.size();
        c2 = cyc;
        m0_valid = 1'b1; m0_awaddr = 10'h00C; m0_wdata = 32'h0000_0022;
        tick();
        m0_valid = 1'b0;
        tick(10);
        check("t5 reissue count", 64'(iss_cyc.size() - b2), 64'd1);
        if (iss_cyc.size() > b2) check("t5 reissue cycle", 64'(iss_cyc[b2] - c2), 64'd2);

`ifdef LITE_ARB_TIMEOUT_EN
        // No completion: abort TIMEOUT_CYC cycles after ISSUE; late lite_end ignored.
        resp_en = 1'b0;
        do_reset(2);
        b = iss_cyc.size(); e0b = end0_cyc.size();
        c = cyc;
        m0_valid = 1'b1; m0_awaddr = 10'h014; m0_wdata = 32'h0000_0033;
        tick();
        m0_valid = 1'b0;
        tick(20);
        check("t6 end count", 64'(end0_cyc.size() - e0b), 64'd1);
        if (end0_cyc.size() > e0b) check("t6 end cycle", 64'(end0_cyc[e0b] - c), 64'd18);
        check("t6 arb_err", 64'(arb_err), 64'd1);
        man_end = 1'b1;
        tick();
        man_end = 1'b0;
        tick(4);
        check("t6 late end ignored", 64'(end0_cyc.size() - e0b), 64'd1);
        check("t6 issue count", 64'(iss_cyc.size() - b), 64'd1);
        check("t6 m0_busy", 64'(m0_busy), 64'd0);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lite_wr_arbiter.md
Name: lite_wr_arbiter

Overview:
- Shares the single AXI-Lite write master (lite_wdata/lite_awaddr/lite_valid/lite_end) between two register-programming requesters: port 0 (MM2S control) and port 1 (S2MM control).
- Buffers one pending write per requester and grants round-robin.
- Issues exactly one lite_valid pulse per write and routes lite_end back to the owning requester as a one-cycle done pulse.

Parameters:
- ADDR_W, 10, register address width.
- DATA_W, 32, register data width.
- TIMEOUT_CYC, 256, cycles to wait for lite_end before abort; used only when LITE_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m0_awaddr  in  ADDR_W  requester 0 register address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_valid  in  1  requester 0 request pulse; addr/data sampled in the same cycle
- m0_end  out  1  one-cycle pulse: requester 0 write completed
- m0_busy  out  1  requester 0 slot occupied (pending or in flight)
- m1_awaddr, m1_wdata, m1_valid, m1_end, m1_busy: same as m0_*, for requester 1
- lite_awaddr  out  ADDR_W  address to AXI-Lite master
- lite_wdata  out  DATA_W  data to AXI-Lite master
- lite_valid  out  1  one-cycle start pulse to AXI-Lite master
- lite_end  in  1  AXI-Lite master write-complete pulse
- req_drop  out  2  sticky per-port flag: request dropped because slot was busy
- arb_err  out  1  sticky timeout flag; constant 0 without the feature

Behaviour:
- Reset values: all outputs 0, both slots empty, FSM IDLE, round-robin pointer favours port 0.
- Slot capture:
  - mN_valid with slot empty: capture addr/data; mN_busy=1 from the next cycle.
  - mN_valid with slot full: request discarded; req_drop[N] set, cleared only by rst.
- FSM, one-hot: IDLE=3'b001, ISSUE=3'b010, WAIT_END=3'b100.
- IDLE:
  - Any slot full -> grant and go to ISSUE.
  - Both full -> grant the port not served last; after reset, port 0 first.
  - On the transition, register lite_awaddr/lite_wdata from the granted slot and set lite_valid=1.
- ISSUE: lasts exactly one cycle, lite_valid=1; then WAIT_END with lite_valid=0.
- lite_awaddr/lite_wdata stay stable from ISSUE until the cycle after lite_end, then return to 0.
- Completion (ISSUE or WAIT_END):
  - lite_end -> next cycle: mN_end=1 for the granted port, its slot cleared (mN_busy=0), pointer updated, FSM IDLE.
  - mN_valid in that same cycle is accepted.
- Latency:
  - mN_valid at cycle 0 with the arbiter idle -> lite_valid at cycle 2.
  - lite_end at cycle t -> mN_end at t+1.
  - Next grant's lite_valid earliest at t+2.
- lite_end in IDLE is ignored; no end pulse is generated.
- Simultaneous mN_valid on both ports, both slots empty: both captured; arbitration order follows the pointer.
- Reset at any point, including mid WAIT_END: slots flushed, no mN_end emitted, outputs 0 in the next cycle.

Optional Feature:
- Macro: LITE_ARB_TIMEOUT_EN.
- Defined:
  - Counter runs in ISSUE/WAIT_END.
  - Reaching TIMEOUT_CYC cycles after ISSUE without lite_end: set arb_err (sticky), pulse mN_end for the granted port, clear its slot, return to IDLE.
  - Completes the same as a normal lite_end; a late lite_end then arrives in IDLE and is ignored.
- Undefined: no counter; WAIT_END holds indefinitely; arb_err tied 0.

Decomposition:
- Package lite_arb_pkg holds: FSM state encodings, port index constants (PORT_MM2S=0, PORT_S2MM=1), default ADDR_W/DATA_W.
- One sub-module, lite_req_slot: single-entry holding register with capture, clear and drop-flag logic; instantiated per port.

Test Plan:
- m0 write: awaddr 0x00, wdata 0x0101_1005, lite_end 4 cycles after lite_valid -> lite_valid only at cycle 2 with those values; m0_end 1 cycle after lite_end; m0_busy 0 after.
- m0_valid (0x18, 0x1000_0000) and m1_valid (0x48, 0x2000_0000) in the same cycle after reset -> port 0 issued first, then port 1; m0_end precedes m1_end.
- Both slots kept refilled for 4 transactions -> grant order 0,1,0,1; no req_drop.
- m1_valid pulsed again while m1_busy=1 -> second request absent on lite bus; req_drop=2'b10; first write completes normally.
- rst asserted in WAIT_END, lite_end pulsed afterwards -> no mN_end; all outputs 0; next m0_valid yields lite_valid 2 cycles later.
- LITE_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, no lite_end -> arb_err=1 and m0_end pulse 16 cycles after ISSUE; a later lite_end has no effect.
